// File: rtl/sr04_ranger.sv
// HC-SR04 ultrasonic ranging front-end: periodic trigger, echo width timing,
// and width-to-centimetre conversion by repeated subtraction.
module sr04_ranger #(
  parameter int TRIG_LEN = 10,
  parameter int PERIOD   = 60000,
  parameter int TIMEOUT  = 30000,
  parameter int DIV      = 58
) (
  input  logic        clk_1m,
  input  logic        rst_n,
  input  logic        en,
  output logic        s1_trig,
  input  logic        s1_echo,
  output logic [15:0] echo_us,
  output logic [15:0] dist_cm,
  output logic        dist_vld,
  output logic        err
);

  // state   | meaning
  // IDLE    | stopped, waiting for en
  // TRIG    | trigger pin high for TRIG_LEN cycles
  // WAIT_HI | waiting for echo rise, bounded by TIMEOUT
  // MEAS    | counting echo width
  // CONV    | width / DIV, one subtraction per cycle
  // ERR     | report timeout result
  // HOLD    | idle until the period boundary
  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_HI, S_MEAS, S_CONV, S_ERR, S_HOLD
  } state_t;

  localparam logic [15:0] L_TRIG_END = 16'(TRIG_LEN - 1);
  localparam logic [15:0] L_PER_END  = 16'(PERIOD - 1);
  localparam logic [15:0] L_TMO      = 16'(TIMEOUT);
  localparam logic [15:0] L_TMO_END  = 16'(TIMEOUT - 1);
  localparam logic [15:0] L_DIV      = 16'(DIV);

  state_t      r_state;
  logic        r_echo_m;
  logic        r_echo_s;
  logic [15:0] r_per;
  logic [15:0] r_tmr;
  logic [15:0] r_width;
  logic [15:0] r_rem;
  logic [9:0]  r_quo;

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_m <= 1'b0;
      r_echo_s <= 1'b0;
    end else begin
      r_echo_m <= s1_echo;
      r_echo_s <= r_echo_m;
    end
  end

  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_per    <= '0;
      r_tmr    <= '0;
      r_width  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      s1_trig  <= 1'b0;
      echo_us  <= '0;
      dist_cm  <= '0;
      dist_vld <= 1'b0;
      err      <= 1'b0;
    end else begin
      dist_vld <= 1'b0;
      err      <= 1'b0;
      r_per    <= (r_per == L_PER_END) ? '0 : r_per + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_per <= '0;
          if (en) begin
            r_state <= S_TRIG;
            s1_trig <= 1'b1;
            r_tmr   <= '0;
          end
        end
        S_TRIG: begin
          if (r_tmr == L_TRIG_END) begin
            r_state <= S_WAIT_HI;
            s1_trig <= 1'b0;
            r_tmr   <= '0;
            r_width <= '0;
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
        S_WAIT_HI: begin
          if (r_echo_s) begin
            r_state <= S_MEAS;
            r_width <= 16'd1;
          end else if (r_tmr == L_TMO_END) begin
            r_state <= S_ERR;
            r_width <= '0;
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
        S_MEAS: begin
          // width saturates at TIMEOUT; a still-high echo there is an error
          if (!r_echo_s) begin
            r_state <= S_CONV;
            r_rem   <= r_width;
            r_quo   <= '0;
          end else if (r_width == L_TMO) begin
            r_state <= S_ERR;
          end else begin
            r_width <= r_width + 16'd1;
          end
        end
        S_CONV: begin
          if (r_rem >= L_DIV) begin
            r_rem <= r_rem - L_DIV;
            r_quo <= r_quo + 10'd1;
          end else begin
            echo_us  <= r_width;
            dist_cm  <= {6'd0, r_quo};
            dist_vld <= 1'b1;
            r_state  <= S_HOLD;
          end
        end
        S_ERR: begin
          echo_us  <= r_width;
          dist_cm  <= 16'hFFFF;
          dist_vld <= 1'b1;
          err      <= 1'b1;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          if (r_per == L_PER_END) begin
            if (en) begin
              r_state <= S_TRIG;
              s1_trig <= 1'b1;
              r_tmr   <= '0;
              r_per   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr04_ranger.sv
// Scoreboard bench for sr04_ranger using shortened period/timeout so the
// whole run stays short; expected results are hand-computed widths and quotients.
`timescale 1ns/1ps
module tb_sr04_ranger;

  localparam int TRIG_LEN = 10;
  localparam int PERIOD   = 3000;
  localparam int TIMEOUT  = 2000;
  localparam int DIV      = 58;

  logic        clk_1m = 1'b0;
  logic        rst_n;
  logic        en;
  logic        s1_trig;
  logic        s1_echo;
  logic [15:0] echo_us;
  logic [15:0] dist_cm;
  logic        dist_vld;
  logic        err;

  always #5 clk_1m = ~clk_1m;

  sr04_ranger #(
    .TRIG_LEN(TRIG_LEN), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .DIV(DIV)
  ) dut (
    .clk_1m(clk_1m), .rst_n(rst_n), .en(en), .s1_trig(s1_trig),
    .s1_echo(s1_echo), .echo_us(echo_us), .dist_cm(dist_cm),
    .dist_vld(dist_vld), .err(err)
  );

  typedef struct packed {
    logic [15:0] us;
    logic [15:0] cm;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rise_cyc;
  int   t_prev;
  logic prev_vld = 1'b0;

  always @(posedge clk_1m) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_exp(input int us, input int cm, input bit e);
    exp_t x;
    x.us = 16'(us);
    x.cm = 16'(cm);
    x.e  = e;
    exp_q.push_back(x);
  endtask

  // monitor: pops one expectation per dist_vld strobe
  always @(negedge clk_1m) begin
    exp_t x;
    if (dist_vld === 1'b1) begin
      check("dist_vld one cycle", int'(prev_vld), 0);
      if (exp_q.size() == 0) begin
        check("unexpected dist_vld", int'(dist_vld), 0);
      end else begin
        x = exp_q.pop_front();
        check("echo_us", int'(echo_us), int'(x.us));
        check("dist_cm", int'(dist_cm), int'(x.cm));
        check("err with dist_vld", int'(err), int'(x.e));
      end
    end
    if (err === 1'b1) check("dist_vld with err", int'(dist_vld), 1);
    prev_vld <= dist_vld;
  end

  task automatic wait_rise(output int n);
    n = 0;
    while (s1_trig !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk_1m);
      n++;
    end
    if (s1_trig !== 1'b1) check("trigger rise timeout", int'(s1_trig), 1);
    rise_cyc = cyc;
  endtask

  task automatic wait_fall(output int w);
    w = 0;
    while (s1_trig === 1'b1 && w < 4 * TRIG_LEN) begin
      w++;
      @(negedge clk_1m);
    end
  endtask

  task automatic drive_echo(input int dly, input int n);
    repeat (dly) @(negedge clk_1m);
    s1_echo = 1'b1;
    repeat (n) @(negedge clk_1m);
    s1_echo = 1'b0;
  endtask

  task automatic wait_vld(output int c);
    c = 0;
    do begin
      @(negedge clk_1m);
      c++;
    end while (dist_vld !== 1'b1 && c < 4 * TIMEOUT);
    if (dist_vld !== 1'b1) check("dist_vld timeout", int'(dist_vld), 1);
  endtask

  task automatic do_meas(input int dly, input int n, input bit push, input int cm, input bit chk_per);
    int r, w;
    wait_rise(r);
    if (chk_per) check("trigger period", rise_cyc - t_prev, PERIOD);
    t_prev = rise_cyc;
    wait_fall(w);
    check("trigger width", w, TRIG_LEN);
    if (push) push_exp(n, cm, 1'b0);
    drive_echo(dly, n);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w, c, nr;
    logic p;
    s1_echo = 1'b0;
    en      = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk_1m);
    check("reset s1_trig", int'(s1_trig), 0);
    check("reset dist_vld", int'(dist_vld), 0);
    check("reset err", int'(err), 0);
    check("reset dist_cm", int'(dist_cm), 0);
    check("reset echo_us", int'(echo_us), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_1m);
    en = 1'b1;

    // 580 us echo, 300 us after trigger
    wait_rise(r);
    check("first trigger latency", r, 1);
    t_prev = rise_cyc;
    wait_fall(w);
    check("trigger width", w, TRIG_LEN);
    push_exp(580, 10, 1'b0);
    drive_echo(300, 580);
    wait_vld(c);
    check_range("580us dist_vld latency", c, 10 + 2, 10 + 4);

    do_meas(300, 57, 1'b1, 0, 1'b1);
    do_meas(300, 1160, 1'b1, 20, 1'b1);
    // glitch during conversion must not disturb the result
    repeat (4) @(negedge clk_1m);
    s1_echo = 1'b1;
    repeat (3) @(negedge clk_1m);
    s1_echo = 1'b0;
    do_meas(300, 58, 1'b1, 1, 1'b1);
    do_meas(300, 1990, 1'b1, 34, 1'b1);

    // echo never rises
    wait_rise(r);
    check("trigger period", rise_cyc - t_prev, PERIOD);
    t_prev = rise_cyc;
    wait_fall(w);
    push_exp(0, 16'hFFFF, 1'b1);
    c = 0;
    do begin
      @(negedge clk_1m);
      c++;
    end while (err !== 1'b1 && c < 3 * TIMEOUT);
    check_range("no-echo err latency", c, TIMEOUT + 1, TIMEOUT + 3);

    // echo stuck high from inside TRIG
    wait_rise(r);
    check("trigger period", rise_cyc - t_prev, PERIOD);
    t_prev = rise_cyc;
    s1_echo = 1'b1;
    push_exp(TIMEOUT, 16'hFFFF, 1'b1);
    wait_vld(c);
    s1_echo = 1'b0;

    // en dropped mid-measurement: result reported, then no more triggers
    wait_rise(r);
    check("trigger period", rise_cyc - t_prev, PERIOD);
    wait_fall(w);
    push_exp(1160, 20, 1'b0);
    repeat (100) @(negedge clk_1m);
    s1_echo = 1'b1;
    repeat (500) @(negedge clk_1m);
    en = 1'b0;
    repeat (660) @(negedge clk_1m);
    s1_echo = 1'b0;
    wait_vld(c);
    nr = 0;
    p  = s1_trig;
    repeat (3 * PERIOD) begin
      @(negedge clk_1m);
      if (s1_trig === 1'b1 && p !== 1'b1) nr++;
      p = s1_trig;
    end
    check("triggers after en drop", nr, 0);

    // reset during TRIG
    en = 1'b1;
    wait_rise(r);
    check("restart trigger latency", r, 1);
    repeat (3) @(negedge clk_1m);
    #1 rst_n = 1'b0;
    #1;
    check("rst in TRIG s1_trig", int'(s1_trig), 0);
    check("rst in TRIG echo_us", int'(echo_us), 0);
    check("rst in TRIG dist_cm", int'(dist_cm), 0);
    check("rst in TRIG dist_vld", int'(dist_vld), 0);
    check("rst in TRIG err", int'(err), 0);
    repeat (2) @(negedge clk_1m);
    rst_n = 1'b1;
    do_meas(300, 580, 1'b1, 10, 1'b0);
    wait_vld(c);

    // reset during CONV: that result must never appear
    do_meas(300, 1990, 1'b0, 0, 1'b1);
    repeat (10) @(negedge clk_1m);
    #1 rst_n = 1'b0;
    #1;
    check("rst in CONV s1_trig", int'(s1_trig), 0);
    check("rst in CONV echo_us", int'(echo_us), 0);
    check("rst in CONV dist_cm", int'(dist_cm), 0);
    repeat (2) @(negedge clk_1m);
    rst_n = 1'b1;
    do_meas(200, 116, 1'b1, 2, 1'b0);
    wait_vld(c);

    repeat (5) @(negedge clk_1m);
    check("pending expectations", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr04_ranger.md
# sr04_ranger

Ultrasonic ranging front-end inside the VFD top level. It drives the HC-SR04 trigger pin, times the returned echo pulse on the 1 MHz clock (one cycle = 1 µs), and converts the pulse width to centimetres. It delivers a distance word plus a one-cycle valid strobe to the display/PWM logic downstream. It repeats the measurement on a fixed period while enabled.

## Interface
Parameters:
- TRIG_LEN, 10: trigger pulse width in clk_1m cycles (µs).
- PERIOD, 60000: trigger-to-trigger interval in cycles. Must be greater than TRIG_LEN + TIMEOUT + 600.
- TIMEOUT, 30000: maximum cycles allowed for each of these phases: waiting for echo rise, and echo high.
- DIV, 58: µs-per-cm divisor.

Ports:
- clk_1m  in  1  1 MHz system clock for this block.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  enables periodic ranging.
- s1_trig  out  1  trigger to sensor.
- s1_echo  in  1  echo from sensor; asynchronous, synchronised internally.
- echo_us  out  16  last measured echo width in µs.
- dist_cm  out  16  last distance in cm; 16'hFFFF on error.
- dist_vld  out  1  one-cycle strobe when dist_cm/echo_us update.
- err  out  1  one-cycle strobe on timeout; coincides with dist_vld.

One clock; reset is asynchronous and active-low (clk_1m, rst_n).

## Operation
- s1_echo passes through a 2-flop synchroniser to produce echo_s. Only echo_s is used internally.
- A period counter runs 0..PERIOD-1. It is cleared on entry to TRIG.

State machine:
- IDLE: s1_trig=0. If en=1, go to TRIG.
- TRIG: s1_trig=1 for exactly TRIG_LEN cycles, then go to WAIT_HI. The timeout counter is cleared on exit.
- WAIT_HI:
  - If echo_s=1, go to MEAS with width counter = 1.
  - Otherwise, when the timeout counter reaches TIMEOUT-1, take the error exit.
- MEAS:
  - While echo_s=1, increment the width counter.
  - If echo_s=0, go to CONV.
  - If the width counter reaches TIMEOUT while echo_s is still 1, take the error exit.
- CONV: repeated subtraction, one subtraction of DIV per cycle.
  - remainder starts at width; quotient starts at 0.
  - While remainder ≥ DIV: remainder -= DIV and quotient += 1.
  - When done, register echo_us=width and dist_cm=quotient, pulse dist_vld, go to HOLD.
- Error exit: dist_cm=16'hFFFF and echo_us=width counter value (0 if the timeout occurred in WAIT_HI). Pulse dist_vld and err together, then go to HOLD.
- HOLD: wait until the period counter = PERIOD-1.
  - Then, if en=1, go to TRIG; otherwise go to IDLE.

Arithmetic:
- Counters are 16 bits.
- The width counter saturates at TIMEOUT and never wraps.
- The quotient is floor(width/DIV) and fits in 10 bits; it is zero-extended to 16 bits.

Boundary conditions:
- en drop mid-cycle: the current measurement completes and its result is reported. The block then stops in IDLE at the period boundary. No new trigger is issued.
- Echo already high during TRIG, from a stuck sensor: it is ignored until WAIT_HI. In WAIT_HI it is counted from the first WAIT_HI cycle.
- Echo glitches after MEAS exits are ignored until the next WAIT_HI.

## Timing
Reset values:
- s1_trig=0, dist_vld=0, err=0.
- dist_cm=0, echo_us=0.
- State IDLE; all counters and synchroniser flops 0.

Reset asserted mid-operation:
- All outputs return to their reset values asynchronously. s1_trig falls immediately.

Trigger timing:
- First s1_trig rise comes 1 cycle after en is sampled high in IDLE.
- Trigger rising edges are exactly PERIOD cycles apart while en=1.

Measurement latency:
- An echo high for N whole clk_1m cycles yields echo_us=N (±1 for asynchronous edge alignment).
- dist_vld asserts floor(N/DIV)+3 cycles (±1) after the raw echo falling edge.

Outputs:
- dist_vld and err are exactly one cycle wide.
- dist_cm and echo_us hold their values until the next dist_vld.

No-echo error timing:
- err asserts TIMEOUT+2 cycles (±1) after s1_trig falls.

## Test plan
- Echo of 580 µs, 300 µs after trigger → echo_us=580, dist_cm=10, one dist_vld, err=0; s1_trig high exactly 10 cycles.
- Echo of 57 µs → dist_cm=0. Echo of 1160 µs → dist_cm=20. Echo of 29000 µs → dist_cm=500.
- Echo never rises → err and dist_vld together ~30002 cycles after s1_trig falls; dist_cm=16'hFFFF, echo_us=0.
- Echo stuck high → err when width reaches 30000; dist_cm=16'hFFFF, echo_us=30000.
- en held high for 3 periods → s1_trig rises exactly 60000 cycles apart. Drop en mid-MEAS → that result is still reported, then no further trigger.
- rst_n pulsed low during TRIG and again during CONV → s1_trig=0 and all outputs at 0 immediately. After release with en=1, a normal measurement restarts correctly.
